// File: rtl/updown_mod_counter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | updown_mod_counter_pkg                                                     |
// | Direction/mode constants and next-count helpers shared by counter blocks.  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package updown_mod_counter_pkg;

  typedef enum logic {DIR_DOWN = 1'b0, DIR_UP   = 1'b1} dir_e;
  typedef enum logic {MODE_WRAP = 1'b0, MODE_SAT = 1'b1} mode_e;

  // Helpers work at the widest supported width; callers zero-extend and truncate.
  localparam int CNT_MAX_W = 64;

  function automatic logic [CNT_MAX_W-1:0] next_count(
    input logic [CNT_MAX_W-1:0] cnt,
    input logic                 up,
    input logic                 sat,
    input logic [CNT_MAX_W-1:0] max_val
  );
    logic [CNT_MAX_W-1:0] r;
    r = cnt;
    if (up == DIR_UP) begin
      if (cnt >= max_val) r = (sat == MODE_SAT) ? max_val : '0;
      else                r = cnt + CNT_MAX_W'(1);
    end else begin
      if (cnt == '0) r = (sat == MODE_SAT) ? '0 : max_val;
      else           r = cnt - CNT_MAX_W'(1);
    end
    return r;
  endfunction

  function automatic logic is_boundary(
    input logic [CNT_MAX_W-1:0] cnt,
    input logic                 up,
    input logic [CNT_MAX_W-1:0] max_val
  );
    return (up == DIR_UP) ? (cnt >= max_val) : (cnt == '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/updown_mod_counter_next.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | updown_mod_counter_next                                                    |
// | Combinational next-count and boundary-event detection.                    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module updown_mod_counter_next
  import updown_mod_counter_pkg::*;
#(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
  input  logic [WIDTH-1:0] i_count,
  input  logic             i_up,
  input  logic             i_sat,
  output logic [WIDTH-1:0] o_next,
  output logic             o_boundary
);

  assign o_next = WIDTH'(next_count(CNT_MAX_W'(i_count), i_up, i_sat,
                                    CNT_MAX_W'(MAX_VAL)));
  assign o_boundary = is_boundary(CNT_MAX_W'(i_count), i_up, CNT_MAX_W'(MAX_VAL));

endmodule
`default_nettype wire

// File: rtl/updown_mod_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | updown_mod_counter                                                         |
// | Modulo up/down counter with load, wrap/saturate, tc pulse and sticky ovf.  |
// | Optional compare output enabled by macro UPDOWN_MOD_COUNTER_CMP_EN.        |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module updown_mod_counter
  import updown_mod_counter_pkg::*;
#(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
`ifdef UPDOWN_MOD_COUNTER_CMP_EN
  ,
  input  logic [WIDTH-1:0] cmp_val,
  output logic             cmp_hit
`endif
);

  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic             r_ovf;
  logic [WIDTH-1:0] w_next;
  logic             w_boundary;
  logic [WIDTH-1:0] w_load_clamped;
  logic             w_bnd_evt;
  logic [WIDTH-1:0] w_count_d;

  updown_mod_counter_next #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL)
  ) u_next (
    .i_count    (r_count),
    .i_up       (up),
    .i_sat      (sat),
    .o_next     (w_next),
    .o_boundary (w_boundary)
  );

  assign w_load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;
  // Load has priority over stepping, so a boundary only counts when not loading.
  assign w_bnd_evt      = en && !load && w_boundary;
  assign w_count_d      = load ? w_load_clamped : (en ? w_next : r_count);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_tc    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_count <= w_count_d;
      r_tc    <= w_bnd_evt;
      if (w_bnd_evt)    r_ovf <= 1'b1;
      else if (clr_ovf) r_ovf <= 1'b0;
    end
  end

  assign count = r_count;
  assign tc    = r_tc;
  assign ovf   = r_ovf;

`ifdef UPDOWN_MOD_COUNTER_CMP_EN
  logic r_cmp_hit;

  always_ff @(posedge clk) begin
    if (rst) r_cmp_hit <= 1'b0;
    else     r_cmp_hit <= (w_count_d == cmp_val);
  end

  assign cmp_hit = r_cmp_hit;
`endif

endmodule
`default_nettype wire

// File: tb/tb_updown_mod_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_updown_mod_counter                                                      |
// | Scoreboard bench: directed vectors, WIDTH=4, MAX_VAL=9.                    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_updown_mod_counter;

  localparam int         WIDTH   = 4;
  localparam logic [3:0] MAX_VAL = 4'd9;
  localparam logic [3:0] CMP     = 4'd5;

  typedef struct {
    logic [3:0] count;
    logic       tc;
    logic       ovf;
    logic       cmp;
    string      name;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             en;
  logic             up;
  logic             sat;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             clr_ovf;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             ovf;
`ifdef UPDOWN_MOD_COUNTER_CMP_EN
  logic [WIDTH-1:0] cmp_val;
  logic             cmp_hit;
`endif

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  updown_mod_counter #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .sat      (sat),
    .load     (load),
    .load_val (load_val),
    .clr_ovf  (clr_ovf),
    .count    (count),
    .tc       (tc),
    .ovf      (ovf)
`ifdef UPDOWN_MOD_COUNTER_CMP_EN
    ,
    .cmp_val  (cmp_val),
    .cmp_hit  (cmp_hit)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue the hand-computed response.
  task automatic step(input logic i_rst, input logic i_en, input logic i_up,
                      input logic i_sat, input logic i_load, input logic [3:0] i_lv,
                      input logic i_clr, input logic [3:0] e_cnt, input logic e_tc,
                      input logic e_ovf, input string nm);
    exp_t e;
    @(negedge clk);
    rst = i_rst; en = i_en; up = i_up; sat = i_sat;
    load = i_load; load_val = i_lv; clr_ovf = i_clr;
    e.count = e_cnt; e.tc = e_tc; e.ovf = e_ovf; e.name = nm;
    e.cmp = !i_rst && (e_cnt == CMP);
    q.push_back(e);
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_checks++;
      if (count !== e.count) begin
        n_errors++;
        $display("FAIL %s count: got %0d expected %0d", e.name, count, e.count);
      end
      n_checks++;
      if (tc !== e.tc) begin
        n_errors++;
        $display("FAIL %s tc: got %b expected %b", e.name, tc, e.tc);
      end
      n_checks++;
      if (ovf !== e.ovf) begin
        n_errors++;
        $display("FAIL %s ovf: got %b expected %b", e.name, ovf, e.ovf);
      end
`ifdef UPDOWN_MOD_COUNTER_CMP_EN
      n_checks++;
      if (cmp_hit !== e.cmp) begin
        n_errors++;
        $display("FAIL %s cmp_hit: got %b expected %b", e.name, cmp_hit, e.cmp);
      end
`endif
    end
  end

  initial begin
    logic [3:0] up_cnt [12];
    up_cnt = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
    rst = 1'b1; en = 1'b0; up = 1'b1; sat = 1'b0;
    load = 1'b0; load_val = '0; clr_ovf = 1'b0;
`ifdef UPDOWN_MOD_COUNTER_CMP_EN
    cmp_val = CMP;
`endif
    //   rst en up sat ld lv    clr  cnt   tc ovf
    step(1, 0, 1, 0, 0, 4'd0, 0, 4'd0, 0, 0, "reset");
    step(1, 1, 1, 0, 1, 4'd7, 0, 4'd0, 0, 0, "reset_hold");
    // Wrap-up run: tc only on the step 9 -> 0, ovf sticky afterwards.
    for (int i = 0; i < 12; i++)
      step(0, 1, 1, 0, 0, 4'd0, 0, up_cnt[i], (i == 9), (i >= 9), "wrap_up");
    step(1, 1, 1, 0, 0, 4'd0, 0, 4'd0, 0, 0, "reset_mid");
    step(0, 1, 0, 0, 0, 4'd0, 0, 4'd9, 1, 1, "wrap_down_0");
    step(0, 1, 0, 0, 0, 4'd0, 0, 4'd8, 0, 1, "down_8");
    step(0, 1, 0, 0, 0, 4'd0, 0, 4'd7, 0, 1, "down_7");
    step(0, 0, 1, 1, 0, 4'd0, 0, 4'd7, 0, 1, "hold");
    step(0, 0, 0, 0, 0, 4'd0, 1, 4'd7, 0, 0, "clr_ovf");
    // Saturating up from 8.
    step(0, 0, 1, 1, 1, 4'd8, 0, 4'd8, 0, 0, "load_8");
    step(0, 1, 1, 1, 0, 4'd0, 0, 4'd9, 0, 0, "sat_up_9");
    step(0, 1, 1, 1, 0, 4'd0, 0, 4'd9, 1, 1, "sat_up_hold1");
    step(0, 1, 1, 1, 0, 4'd0, 0, 4'd9, 1, 1, "sat_up_hold2");
    // Saturating down from 1.
    step(0, 0, 0, 1, 1, 4'd1, 0, 4'd1, 0, 1, "load_1");
    step(0, 1, 0, 1, 0, 4'd0, 0, 4'd0, 0, 1, "sat_dn_0");
    step(0, 1, 0, 1, 0, 4'd0, 0, 4'd0, 1, 1, "sat_dn_hold");
    // Load clamps to MAX_VAL and wins over en without a tc.
    step(0, 1, 1, 0, 1, 4'd15, 0, 4'd9, 0, 1, "load_clamp");
    step(1, 1, 1, 0, 1, 4'd3, 0, 4'd0, 0, 0, "reset_run");
    // Boundary event beats a simultaneous clr_ovf.
    step(0, 0, 1, 0, 1, 4'd9, 0, 4'd9, 0, 0, "load_9");
    step(0, 1, 1, 0, 0, 4'd0, 1, 4'd0, 1, 1, "set_vs_clr");
    step(0, 0, 1, 0, 0, 4'd0, 1, 4'd0, 0, 0, "clr_alone");
    // Direction changes take effect on the same edge.
    step(0, 1, 1, 0, 0, 4'd0, 0, 4'd1, 0, 0, "dir_up");
    step(0, 1, 0, 0, 0, 4'd0, 0, 4'd0, 0, 0, "dir_down");
    step(0, 1, 0, 0, 0, 4'd0, 0, 4'd9, 1, 1, "dir_wrap");
    step(0, 1, 0, 0, 1, 4'd3, 0, 4'd3, 0, 1, "load_in_run");
    step(0, 0, 0, 0, 0, 4'd0, 0, 4'd3, 0, 1, "idle");

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/updown_mod_counter.md
# updown_mod_counter

Parametrised synchronous up/down counter generalising the team's fixed 32-bit free-running counter. Adds configurable width and modulus, count enable, direction control, parallel load, wrap-or-saturate mode, a terminal-count pulse and a sticky overflow flag. Used as the common timebase and event counter in datapath and control blocks.

## Interface
- WIDTH, 32, counter width in bits (2..64)
- MAX_VAL, 2**WIDTH-1, highest count value; count range is 0..MAX_VAL; must be ≤ 2**WIDTH-1 and ≥ 1
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  count enable; one step per cycle while high
- up  in  1  direction: 1 increments, 0 decrements
- sat  in  1  boundary mode: 0 wraps, 1 saturates
- load  in  1  parallel load strobe
- load_val  in  WIDTH  value loaded when load=1
- clr_ovf  in  1  clears sticky ovf
- count  out  WIDTH  current count, registered
- tc  out  1  terminal-count pulse, registered
- ovf  out  1  sticky boundary-event flag, registered
- cmp_val  in  WIDTH  compare value (only with CMP_EN)
- cmp_hit  out  1  compare match (only with CMP_EN)

## Operation
- Priority each edge: rst > load > en > hold.
- rst: count=0, tc=0, ovf=0, cmp_hit=0.
- load: count = min(load_val, MAX_VAL); no step, no tc, ovf unchanged except clr_ovf.
- en, up=1, count<MAX_VAL: count+1. At count=MAX_VAL: boundary event; next count = 0 if sat=0, MAX_VAL if sat=1.
- en, up=0, count>0: count-1. At count=0: boundary event; next count = MAX_VAL if sat=0, 0 if sat=1.
- en=0 and load=0: count holds; up, sat ignored.
- Boundary event: tc=1 for exactly the following cycle; ovf set to 1.
- tc=0 on every edge without a boundary event; back-to-back events (sat=1, en held at boundary) give tc high on consecutive cycles.
- ovf: set by boundary event, cleared by clr_ovf; simultaneous set and clr_ovf -> set wins (ovf=1).
- Arithmetic in WIDTH bits; no intermediate value exceeds MAX_VAL; comparisons against MAX_VAL done at WIDTH bits.
- Direction or sat may change any cycle; take effect on that edge.

## Timing
- Latency 1 cycle: inputs sampled at edge N, count/tc/ovf valid after edge N.
- tc and ovf aligned with the count value produced by the boundary step (e.g. count=0 and tc=1 in the same cycle after wrap-up).
- rst mid-count: outputs return to reset values at the next edge regardless of en/load.
- No combinational path from inputs to outputs.

## Configuration
- Macro UPDOWN_MOD_COUNTER_CMP_EN.
- Defined: cmp_val port and cmp_hit output present; cmp_hit registered, = 1 in the cycle after an edge where the new count equals cmp_val; reset 0.
- Undefined: cmp_val and cmp_hit ports absent; no compare logic.

## Structure
- Shared package: direction constants (DIR_DOWN=0, DIR_UP=1), mode constants (MODE_WRAP=0, MODE_SAT=1), and a function computing next count from (count, up, sat, MAX_VAL) reusable by other counters.
- One sub-module natural: updown_mod_counter_next, combinational next-state/boundary-detect; top level holds registers, priority and flags.

## Test plan
- WIDTH=4, MAX_VAL=9, sat=0, up=1, en=1 from reset for 12 cycles -> count 1..9,0,1,2; tc=1 only in cycle count returns to 0; ovf=1 thereafter.
- Same config, up=0 from 0 -> count 9,8,...; tc=1 with first 9; ovf=1.
- sat=1, load_val=8, up=1, en=1 -> 9,9,9; tc high on the two edges stepping at 9; count never 0.
- load=1 with load_val=15 (MAX_VAL=9) and en=1 simultaneously -> count=9, tc=0; then rst=1 mid-run -> count=0, tc=0, ovf=0 next edge.
- Boundary event and clr_ovf on same edge -> ovf=1; clr_ovf next cycle alone -> ovf=0.
- With CMP_EN, cmp_val=5, counting up from 0 -> cmp_hit=1 only in the cycle count=5; without macro, build has no cmp ports.
